hdmi_source_sel: RTL

Frame-synchronous video source controller in the HDMI pixel domain, between the upscaler output and the HDMI encoder. Selects, per frame, between upscaled PPU video and an internal test pattern. A debounced push-button request drives the selection, and changes take effect only at a frame boundary so the encoder never sees a torn frame. The pattern type comes from the board switches and is latched once per frame.

---
 rtl/hdmi_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 49 ++++
 rtl/hdmi_source_sel.sv | 111 +++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and colour constants for the HDMI source-selection path.
package hdmi_pkg;

    typedef enum logic [1:0] {
        VIDEO    = 2'd0,
        PEND_PAT = 2'd1,
        PAT      = 2'd2,
        PEND_VID = 2'd3
    } source_state_t;

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        CHECKER = 2'd1,
        RAMP    = 2'd2,
        FLICKER = 2'd3
    } pattern_mode_t;

    localparam logic [23:0] COL_WHITE   = 24'hffffff;
    localparam logic [23:0] COL_YELLOW  = 24'hffff00;
    localparam logic [23:0] COL_CYAN    = 24'h00ffff;
    localparam logic [23:0] COL_GREEN   = 24'h00ff00;
    localparam logic [23:0] COL_MAGENTA = 24'hff00ff;
    localparam logic [23:0] COL_RED     = 24'hff0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000ff;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd270000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic        sync_p0;
    logic        sync_p1;
    logic        level;
    logic [19:0] cnt;

    // Stage 0/1: metastability filter for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Stage 2: level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt >= DEBOUNCE_CYCLES - 20'd1) begin
                level <= sync_p1;
                rise  <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/hdmi_source_sel.sv
// Frame-synchronous selector between upscaled video and an internal test
// pattern; source changes are deferred to the frame boundary.
module hdmi_source_sel
    import hdmi_pkg::*;
#(
    parameter logic [9:0]  OSCREEN_WIDTH   = 10'd720,
    parameter logic [9:0]  OSCREEN_HEIGHT  = 10'd480,
    parameter logic [9:0]  OFRAME_WIDTH    = 10'd858,
    parameter logic [9:0]  OFRAME_HEIGHT   = 10'd525,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd270000,
    parameter logic [9:0]  BAR_WIDTH       = 10'd90
) (
    input  logic        clk_hdmi,
    input  logic        rst_hdmi,
    input  logic        btn_req,
    input  logic [1:0]  sw_mode,
    input  logic [9:0]  hx,
    input  logic [9:0]  hy,
    input  logic [23:0] rgb_video,
    output logic [23:0] rgb_out,
    output logic        override_active,
    output logic        frame_start
);

    logic          req_toggle;
    logic          fb;
    logic          pat_sel;
    logic          blank;
    logic [2:0]    bar_idx;
    logic          bar_beyond;
    logic [23:0]   pat_rgb;
    logic          parity_q;
    pattern_mode_t mode_q;
    source_state_t state_q;
    source_state_t state_d;
    logic [23:0]   rgb_p1;
    logic          ovr_p1;
    logic          fs_p1;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk_hdmi),
        .rst  (rst_hdmi),
        .btn  (btn_req),
        .rise (req_toggle)
    );

    assign fb      = (hx == OFRAME_WIDTH - 10'd1) && (hy == OFRAME_HEIGHT - 10'd1);
    assign pat_sel = (state_q == PAT) || (state_q == PEND_VID);
    assign blank   = (hx >= OSCREEN_WIDTH) || (hy >= OSCREEN_HEIGHT);

    // A toggle always beats the frame boundary, so a coincident fb is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VIDEO:    if (req_toggle) state_d = PEND_PAT;
            PEND_PAT: if (req_toggle) state_d = VIDEO;
                      else if (fb)    state_d = PAT;
            PAT:      if (req_toggle) state_d = PEND_VID;
            PEND_VID: if (req_toggle) state_d = PAT;
                      else if (fb)    state_d = VIDEO;
            default:  state_d = VIDEO;
        endcase
    end

    always_comb begin
        bar_idx    = 3'd0;
        bar_beyond = ({3'b000, hx} >= 13'd8 * {3'b000, BAR_WIDTH});
        for (int k = 1; k < 8; k++) begin
            if ({3'b000, hx} >= 13'(k) * {3'b000, BAR_WIDTH}) bar_idx = 3'(k);
        end
    end

    always_comb begin
        pat_rgb = COL_BLACK;
        case (mode_q)
            BARS:    pat_rgb = bar_beyond ? COL_BLACK : bar_color(bar_idx);
            CHECKER: pat_rgb = (hx[4] ^ hy[4]) ? COL_WHITE : COL_BLACK;
            RAMP:    pat_rgb = {3{hx[9:2]}};
            FLICKER: pat_rgb = parity_q ? COL_MAGENTA : COL_GREEN;
            default: pat_rgb = COL_BLACK;
        endcase
    end

    // Stage 1: state, per-frame latches and the registered pixel output
    always_ff @(posedge clk_hdmi or posedge rst_hdmi) begin
        if (rst_hdmi) begin
            state_q  <= VIDEO;
            mode_q   <= BARS;
            parity_q <= 1'b0;
            rgb_p1   <= '0;
            ovr_p1   <= 1'b0;
            fs_p1    <= 1'b0;
        end else begin
            state_q <= state_d;
            fs_p1   <= fb;
            ovr_p1  <= pat_sel;
            rgb_p1  <= blank ? COL_BLACK : (pat_sel ? pat_rgb : rgb_video);
            if (fb) begin
                mode_q   <= pattern_mode_t'(sw_mode);
                parity_q <= ~parity_q;
            end
        end
    end

    assign rgb_out         = rgb_p1;
    assign override_active = ovr_p1;
    assign frame_start     = fs_p1;

endmodule
